multi_countdown_timer: RTL and testbench
========================================

# multi_countdown_timer

Parametrised multi-channel countdown timer, the next-generation timer for the lock/chamber controller. Each channel is loaded with a count, decrements once per prescaled tick, and reports expiry both as a sticky level and as a one-cycle pulse. Channels run independently with per-channel pause and optional auto-reload. A shared prescaler lets the block run on the system clock instead of a dedicated 1 Hz clock.

## Interface

- WIDTH, 10: bits per channel counter; maximum count is 2^WIDTH-1, so the default covers 1023 ticks (for example 300/420/480 s).
- CHANNELS, 3: number of independent timers; must be ≥1.
- PRESCALE, 1: clk cycles per tick; must be ≥1; 1 means every cycle is a tick.
- SELW, derived: max(1, clog2(CHANNELS)).

- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  CHANNELS  per-channel load strobe; bit i loads loadValue into channel i.
- loadValue  in  WIDTH  value shared by every channel whose load bit is set this cycle.
- autoReload  in  CHANNELS  per-channel mode; 1 reloads the last loaded value on expiry.
- pause  in  CHANNELS  per-channel freeze; a paused channel ignores ticks.
- sel  in  SELW  channel selected for count readback.
- count  out  WIDTH  remaining count of channel sel; 0 if sel ≥ CHANNELS.
- done  out  CHANNELS  level; bit i = (channel i count == 0).
- expire  out  CHANNELS  registered one-cycle pulse on channel expiry.

## Operation

- Prescaler:
  - Free-running counter 0..PRESCALE-1.
  - tick = (prescaler == PRESCALE-1).
  - Wraps to 0 after PRESCALE-1.
  - Not resynchronised by load or pause.
- Per channel, registers cnt[WIDTH] and rld[WIDTH]. Per-cycle priority, highest first:
  1. reset: cnt←0, rld←0, expire←0.
  2. load[i]: cnt←loadValue, rld←loadValue, expire[i]←0. Pending tick is ignored for this channel.
  3. pause[i] or no tick: cnt holds, expire[i]←0.
  4. tick and cnt>1: cnt←cnt-1, expire[i]←0.
  5. tick and cnt==1 and autoReload[i]: cnt←rld, expire[i]←1.
  6. tick and cnt==1 and not autoReload[i]: cnt←0, expire[i]←1.
  7. tick and cnt==0: hold at 0, expire[i]←0.
- Channel states:
  - IDLE (cnt==0): entered at reset or on expiry. Leaves only on load.
  - RUN (cnt>0, not paused).
  - PAUSED (cnt>0, pause=1). Returns to RUN when pause drops, with no count lost.
- Expiry from IDLE never occurs: auto-reload fires only on the 1→0 transition.
- Load with loadValue=0: channel goes to IDLE, done=1, no expire pulse.
- Load while RUN or PAUSED restarts the channel from the new value. The pause level still applies.
- autoReload with rld=1: the channel expires on every tick and count stays 1.
- Arithmetic is unsigned WIDTH bits. Decrement never wraps below 0.

## Timing

- Reset values:
  - count=0
  - done=all ones
  - expire=0
  - prescaler=0
  - all rld=0
- Load latency: cnt shows loadValue, and done reflects it, in the cycle after the edge that samples load.
- Tick latency: first decrement occurs at the edge where tick=1. With PRESCALE=P, a channel loaded with N (no pause) reaches 0 at most N·P and at least (N-1)·P+1 edges after load.
- expire[i] is high for exactly one cycle: the first cycle in which cnt shows 0 (one-shot) or the reloaded value (auto-reload).
- done is combinational from cnt. It rises in the same cycle as expire in one-shot mode and stays high until a nonzero load.
- count is combinational from the registers and sel, with zero latency on sel change.
- Reset mid-count aborts all channels immediately with no expire pulse. It dominates a simultaneous load.
- Simultaneous load on several channels: all take the same loadValue.

## Test plan

- Reset: after reset with WIDTH=10, CHANNELS=3, PRESCALE=4 → count=0, done=3'b111, expire=0 for every sel.
- One-shot: load[0] with 5, PRESCALE=1 → count 5,4,3,2,1,0 on successive cycles; expire[0] one pulse coincident with 0; done[0] stays 1 for 20 further cycles.
- Prescale and pause:
  - Stimulus: PRESCALE=4, load ch1=3, pause[1] high for 10 cycles mid-count.
  - Response: decrement only on every 4th edge; count frozen during pause; total expiry delay extended by the paused ticks.
- Auto-reload: ch2 autoReload=1, load 2 → count 2,1,2,1…, expire[2] pulses every 2 ticks, done[2] never asserts. Then autoReload=0 → stops at 0 with one final pulse.
- Collisions:
  - Load on the same edge as a tick: no decrement.
  - Load 0 on a running channel: done=1, no expire.
  - Load on channels 0 and 2 together with value 7: both read 7.
  - sel=3: count=0.
- Reset mid-run: channels at 100/50/1 with tick pending, reset asserted → all counts 0, no expire pulse in that cycle or the next.

Source files
------------

// File: rtl/multi_countdown_timer.sv
// Multi-channel countdown timer with a shared tick prescaler, per-channel pause,
// optional auto-reload, sticky done level and one-cycle expire pulse.
module multi_countdown_timer #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] load,
  input  logic [WIDTH-1:0]    loadValue,
  input  logic [CHANNELS-1:0] autoReload,
  input  logic [CHANNELS-1:0] pause,
  input  logic [SELW-1:0]     sel,
  output logic [WIDTH-1:0]    count,
  output logic [CHANNELS-1:0] done,
  output logic [CHANNELS-1:0] expire
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]       presc;
  logic [PW-1:0]       presc_nxt;
  logic                tick;
  logic [WIDTH-1:0]    cnt      [CHANNELS];
  logic [WIDTH-1:0]    cnt_nxt  [CHANNELS];
  logic [WIDTH-1:0]    rld      [CHANNELS];
  logic [WIDTH-1:0]    rld_nxt  [CHANNELS];
  logic [CHANNELS-1:0] expire_nxt;

  // Free-running prescaler; never resynchronised by load or pause.
  assign tick      = (presc == PW'(PRESCALE - 1));
  assign presc_nxt = tick ? '0 : presc + PW'(1);

  // Per-channel next state: load beats tick, paused channels ignore ticks,
  // expiry happens only on the 1 -> 0 step.
  always_comb begin
    expire_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt[i] = cnt[i];
      rld_nxt[i] = rld[i];
      if (load[i]) begin
        cnt_nxt[i] = loadValue;
        rld_nxt[i] = loadValue;
      end else if (tick && !pause[i]) begin
        if (cnt[i] > WIDTH'(1)) begin
          cnt_nxt[i] = cnt[i] - WIDTH'(1);
        end else if (cnt[i] == WIDTH'(1)) begin
          expire_nxt[i] = 1'b1;
          cnt_nxt[i]    = autoReload[i] ? rld[i] : '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc  <= '0;
      expire <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
        rld[i] <= '0;
      end
    end else begin
      presc  <= presc_nxt;
      expire <= expire_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= cnt_nxt[i];
        rld[i] <= rld_nxt[i];
      end
    end
  end

  // Readback mux; out-of-range selects fall through to zero.
  always_comb begin
    count = '0;
    done  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      done[i] = (cnt[i] == '0);
      if (sel == SELW'(i)) count = cnt[i];
    end
  end

endmodule

// File: tb/tb_multi_countdown_timer.sv
// Bench for multi_countdown_timer: two instances (PRESCALE 1 and 4) share stimulus
// and are checked every cycle against a tick-counting behavioural model.
module tb_multi_countdown_timer;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned CH    = 3;
  localparam int unsigned PS [2] = '{1, 4};

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [CH-1:0]    load = '0;
  logic [WIDTH-1:0] loadValue = '0;
  logic [CH-1:0]    autoReload = '0;
  logic [CH-1:0]    pause = '0;
  logic [1:0]       sel = '0;
  logic [WIDTH-1:0] count1, count4;
  logic [CH-1:0]    done1, done4, expire1, expire4;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  int unsigned m_cnt [2][CH];
  int unsigned m_rld [2][CH];
  bit          m_exp [2][CH];
  int unsigned m_k   [2];

  int unsigned ar_cnt [4] = '{1, 2, 1, 2};
  int unsigned ar_exp [4] = '{0, 1, 0, 1};

  multi_countdown_timer #(.WIDTH(WIDTH), .CHANNELS(CH), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .loadValue(loadValue),
    .autoReload(autoReload), .pause(pause), .sel(sel),
    .count(count1), .done(done1), .expire(expire1)
  );

  multi_countdown_timer #(.WIDTH(WIDTH), .CHANNELS(CH), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .load(load), .loadValue(loadValue),
    .autoReload(autoReload), .pause(pause), .sel(sel),
    .count(count4), .done(done4), .expire(expire4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: the k-th edge after reset is a tick when k mod P == P-1.
  always @(posedge clk) begin
    bit t;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_k[d] = 0;
        for (int c = 0; c < CH; c++) begin
          m_cnt[d][c] = 0;
          m_rld[d][c] = 0;
          m_exp[d][c] = 0;
        end
      end else begin
        t = ((m_k[d] % PS[d]) == PS[d] - 1);
        m_k[d] = m_k[d] + 1;
        for (int c = 0; c < CH; c++) begin
          m_exp[d][c] = 0;
          if (load[c]) begin
            m_cnt[d][c] = 32'(loadValue);
            m_rld[d][c] = 32'(loadValue);
          end else if (t && !pause[c] && m_cnt[d][c] != 0) begin
            if (m_cnt[d][c] == 1) begin
              m_exp[d][c] = 1;
              m_cnt[d][c] = autoReload[c] ? m_rld[d][c] : 0;
            end else begin
              m_cnt[d][c] = m_cnt[d][c] - 1;
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        int unsigned ecount;
        int unsigned edone;
        int unsigned eexp;
        ecount = (32'(sel) < CH) ? m_cnt[d][sel] : 0;
        edone = 0;
        eexp  = 0;
        for (int c = 0; c < CH; c++) begin
          if (m_cnt[d][c] == 0) edone = edone | (32'd1 << c);
          if (m_exp[d][c])      eexp  = eexp  | (32'd1 << c);
        end
        chk(d == 0 ? "model_count_p1"  : "model_count_p4",
            d == 0 ? 32'(count1) : 32'(count4), ecount);
        chk(d == 0 ? "model_done_p1"   : "model_done_p4",
            d == 0 ? 32'(done1) : 32'(done4), edone);
        chk(d == 0 ? "model_expire_p1" : "model_expire_p4",
            d == 0 ? 32'(expire1) : 32'(expire4), eexp);
      end
    end
  end

  initial begin
    // Reset
    cyc(1);
    cmp_en = 1'b1;
    cyc(1);
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("reset_count_p4", 32'(count4), 0);
      chk("reset_done_p4", 32'(done4), 7);
      chk("reset_expire_p4", 32'(expire4), 0);
    end
    cyc(1);

    // One-shot countdown from 5 at PRESCALE=1
    sel = 2'd0;
    load = 3'b001;
    loadValue = 10'd5;
    cyc(1);
    load = '0;
    chk("oneshot_count_0", 32'(count1), 5);
    chk("oneshot_done_0", 32'(done1[0]), 0);
    for (int j = 1; j <= 5; j++) begin
      cyc(1);
      chk("oneshot_count", 32'(count1), 32'(5 - j));
      chk("oneshot_expire", 32'(expire1[0]), (j == 5) ? 1 : 0);
    end
    chk("oneshot_done_at_zero", 32'(done1[0]), 1);
    cyc(20);
    chk("oneshot_done_sticky", 32'(done1[0]), 1);
    chk("oneshot_expire_gone", 32'(expire1[0]), 0);

    // Prescale 4 with a 10-cycle pause; phase fixed by a fresh reset (edge E0)
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    load = 3'b010;
    loadValue = 10'd3;
    sel = 2'd1;
    cyc(1);
    load = '0;
    chk("ps_loaded", 32'(count4), 3);
    cyc(3);
    chk("ps_first_tick_e4", 32'(count4), 2);
    pause = 3'b010;
    cyc(10);
    chk("ps_frozen_e14", 32'(count4), 2);
    pause = '0;
    cyc(2);
    chk("ps_resume_e16", 32'(count4), 1);
    cyc(3);
    chk("ps_hold_e19", 32'(count4), 1);
    chk("ps_no_expire_e19", 32'(expire4[1]), 0);
    cyc(1);
    chk("ps_zero_e20", 32'(count4), 0);
    chk("ps_expire_e20", 32'(expire4[1]), 1);
    chk("ps_done_e20", 32'(done4[1]), 1);
    cyc(1);
    chk("ps_expire_once", 32'(expire4[1]), 0);

    // Load on the same edge as a tick (E24) does not decrement
    cyc(2);
    sel = 2'd0;
    load = 3'b001;
    loadValue = 10'd9;
    cyc(1);
    load = '0;
    chk("load_on_tick_p4", 32'(count4), 9);
    chk("load_on_tick_p1", 32'(count1), 9);
    cyc(3);
    chk("load_on_tick_hold", 32'(count4), 9);
    cyc(1);
    chk("load_on_tick_next", 32'(count4), 8);

    // Auto-reload with value 2
    sel = 2'd2;
    autoReload = 3'b100;
    load = 3'b100;
    loadValue = 10'd2;
    cyc(1);
    load = '0;
    chk("ar_loaded", 32'(count1), 2);
    for (int j = 0; j < 4; j++) begin
      cyc(1);
      chk("ar_count", 32'(count1), ar_cnt[j]);
      chk("ar_expire", 32'(expire1[2]), ar_exp[j]);
      chk("ar_done_low", 32'(done1[2]), 0);
    end
    autoReload = '0;
    cyc(1);
    chk("ar_off_count", 32'(count1), 1);
    cyc(1);
    chk("ar_final_count", 32'(count1), 0);
    chk("ar_final_expire", 32'(expire1[2]), 1);
    chk("ar_final_done", 32'(done1[2]), 1);
    cyc(1);
    chk("ar_final_quiet", 32'(expire1[2]), 0);

    // Load 0 on a running channel
    sel = 2'd0;
    load = 3'b001;
    loadValue = 10'd6;
    cyc(1);
    load = '0;
    cyc(2);
    chk("run_before_zero", 32'(count1), 4);
    load = 3'b001;
    loadValue = 10'd0;
    cyc(1);
    load = '0;
    chk("load0_count", 32'(count1), 0);
    chk("load0_done", 32'(done1[0]), 1);
    chk("load0_no_expire", 32'(expire1[0]), 0);
    cyc(1);
    chk("load0_no_expire_next", 32'(expire1[0]), 0);

    // Simultaneous load on channels 0 and 2, then out-of-range select
    load = 3'b101;
    loadValue = 10'd7;
    cyc(1);
    load = '0;
    chk("dual_ch0", 32'(count1), 7);
    sel = 2'd2;
    #1;
    chk("dual_ch2", 32'(count1), 7);
    chk("dual_ch2_p4", 32'(count4), 7);
    sel = 2'd3;
    #1;
    chk("sel3_p1", 32'(count1), 0);
    chk("sel3_p4", 32'(count4), 0);

    // Reset mid-run with channels at 100/50/1
    cyc(1);
    load = 3'b001;
    loadValue = 10'd102;
    cyc(1);
    load = 3'b010;
    loadValue = 10'd51;
    cyc(1);
    load = 3'b100;
    loadValue = 10'd1;
    cyc(1);
    load = '0;
    sel = 2'd0;
    #1;
    chk("mid_ch0", 32'(count1), 100);
    sel = 2'd1;
    #1;
    chk("mid_ch1", 32'(count1), 50);
    sel = 2'd2;
    #1;
    chk("mid_ch2", 32'(count1), 1);
    reset = 1'b1;
    cyc(1);
    chk("mid_reset_count", 32'(count1), 0);
    chk("mid_reset_done", 32'(done1), 7);
    chk("mid_reset_expire", 32'(expire1), 0);
    reset = 1'b0;
    cyc(1);
    chk("mid_reset_expire_next", 32'(expire1), 0);
    chk("mid_reset_expire_next_p4", 32'(expire4), 0);
    chk("mid_reset_done_next", 32'(done1), 7);

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
